// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared address/instruction widths, reset PC and fetch FSM states
// Rev 1.0
// ============================================================================
package cpu_pkg;

  localparam int c_ADDR_W  = 32;
  localparam int c_INSTR_W = 32;

  localparam logic [c_ADDR_W-1:0] c_RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// fetch_buffer : 2-entry FIFO of {pc, instr} between fetch and decode
// Rev 1.0
// ============================================================================
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = c_ADDR_W,
  parameter int INSTR_W = c_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_clear,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_valid,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [1:0]         o_count
);

  logic [ADDR_W-1:0]  r_pc    [2];
  logic [INSTR_W-1:0] r_instr [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               w_push;
  logic               w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed behind o_valid.
  always_ff @(posedge clk) begin
    if (w_push && !rst && !i_clear) begin
      r_pc[r_wr_ptr]    <= i_pc;
      r_instr[r_wr_ptr] <= i_instr;
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_pc    = r_pc[r_rd_ptr];
  assign o_instr = r_instr[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : single-outstanding imem fetch FSM, next-PC mux, decode buffer
// Rev 1.0
// ============================================================================
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = c_ADDR_W,
  parameter int                INSTR_W  = c_INSTR_W,
  parameter int unsigned       PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_RESET_PC)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_cur,
  output logic [ADDR_W-1:0]  pc_next,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [1:0]        w_count;
  logic              w_push;
  logic              w_pop;
  logic [2:0]        w_post_count;
  logic [ADDR_W-1:0] w_step;

  assign w_step    = ADDR_W'(PC_STEP);
  assign imem_req  = (r_state == REQ) || (r_state == FLUSH);
  assign imem_addr = pc_cur;

  // A branch clears the buffer, so neither a pop nor ack data may land that cycle.
  assign w_push = (r_state == REQ) && imem_ack && !branch_taken;
  assign w_pop  = if_valid && if_ready && !branch_taken;

  assign w_post_count = {1'b0, w_count} + {2'b00, w_push} - {2'b00, w_pop};

  fetch_buffer #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_fetch_buffer (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (branch_taken),
    .i_pc    (pc_cur),
    .i_instr (imem_rdata),
    .o_valid (if_valid),
    .o_pc    (if_pc),
    .o_instr (if_instr),
    .o_count (w_count)
  );

  always_comb begin
    pc_next = pc_cur;
    if (reset) begin
      pc_next = RESET_PC;
    end else if (branch_taken) begin
      pc_next = branch_target;
    end else if (w_push) begin
      pc_next = pc_cur + w_step;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FLUSH keeps the stale request open until memory acknowledges it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!branch_taken && (w_count < 2'd2)) w_state_nxt = REQ;
      end
      REQ: begin
        if (branch_taken) begin
          w_state_nxt = imem_ack ? IDLE : FLUSH;
        end else if (imem_ack) begin
          w_state_nxt = (w_post_count < 3'd2) ? REQ : IDLE;
        end
      end
      FLUSH: begin
        if (!branch_taken && imem_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits around the PC register. It reads the current PC, runs a single-outstanding request/acknowledge transaction with instruction memory, and buffers fetched instructions in a 2-entry queue for the decode stage. It drives the next-PC value back into the PC register: hold, sequential increment, or branch redirect, with flush of stale fetches.

## Interface
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width
- PC_STEP, 1, PC increment per fetched instruction
- RESET_PC, 0, pc_next value while reset is high
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pc_cur  in  ADDR_W  current PC from the PC register
- pc_next  out  ADDR_W  next PC to the PC register (combinational)
- branch_taken  in  1  redirect request from execute
- branch_target  in  ADDR_W  redirect address
- imem_req  out  1  memory request (registered)
- imem_addr  out  ADDR_W  request address, equal to pc_cur
- imem_ack  in  1  memory data valid; completes the request
- imem_rdata  in  INSTR_W  fetched instruction
- if_valid  out  1  buffer head valid to decode
- if_ready  in  1  decode accepts head
- if_instr  out  INSTR_W  head instruction
- if_pc  out  ADDR_W  PC of head instruction

## Operation
- FSM states: IDLE, REQ, FLUSH. imem_req = (state==REQ || state==FLUSH).
- IDLE -> REQ when count<2, where count is the registered buffer occupancy.
- REQ with imem_ack and no branch_taken: push {pc_cur, imem_rdata}; pc_next = pc_cur + PC_STEP (mod 2^ADDR_W, wraps). Next state is REQ if the post-update count<2, else IDLE.
- REQ with no ack: pc_next = pc_cur. imem_addr stays stable.
- branch_taken has top priority in every state:
  - pc_next = branch_target.
  - Buffer is cleared; a pop in the same cycle is ignored.
  - Any same-cycle ack data is discarded.
- Branch in REQ without ack -> FLUSH. Branch in REQ with ack -> IDLE. Branch in IDLE -> IDLE.
- FLUSH: keep imem_req high until imem_ack, discard that data, then -> IDLE. Requests are never withdrawn before ack.
  - pc_next = pc_cur unless branch_taken, which re-redirects and stays in FLUSH.
- Buffer: 2-entry FIFO. Pop when if_valid && if_ready. Push and pop in the same cycle are legal at any occupancy reached; a push never occurs when count==2, guaranteed by the entry condition.
- if_instr and if_pc are undefined-but-stable when if_valid=0; the bench must not check them.

## Timing
- Reset values: state IDLE, count 0, imem_req 0, if_valid 0, buffer pointers 0. pc_next = RESET_PC while reset is high.
- First imem_req: the cycle after the first IDLE cycle following reset deassertion.
- Memory latency is arbitrary, including 0 wait (ack in the first req cycle).
- Ack at cycle N -> if_valid at N+1 if the buffer was empty.
- Zero-wait memory with if_ready held at 1: one instruction per cycle sustained, with PCs consecutive by PC_STEP.
- Branch at cycle N: the cleared buffer is visible at N+1 (if_valid=0). The first request at branch_target is issued at N+2 from IDLE, or after the FLUSH ack.
- Reset mid-transaction returns to IDLE immediately; an in-flight ack after reset is ignored.

## Structure
- Shared package cpu_pkg: ADDR_W/INSTR_W defaults, RESET_PC, fetch state enum (IDLE/REQ/FLUSH).
- Sub-module fetch_buffer: 2-entry FIFO of {pc, instr} with push, pop, clear and count. The FSM and next-PC mux stay in instr_fetch.

## Test plan
- Reset then zero-wait memory, if_ready=1: pc_cur starts at 0. Expect imem_addr 0,1,2,3 on consecutive cycles and if_pc 0,1,2 with matching if_instr.
- if_ready=0 with zero-wait memory: after 2 acks, count=2, imem_req drops to 0 and pc_next holds at 2. Raising if_ready resumes fetch at address 2.
- 3-cycle memory latency: imem_addr 5 held for 3 cycles while pc_next=5. The ack yields pc_next=6, and the entry {5, rdata} appears the next cycle.
- branch_taken (target 0x40) while REQ is waiting at address 8: FLUSH is entered and the later ack data is discarded. The next request is at 0x40 and no instruction from address 8 appears on if_*.
- branch_taken coincident with ack and a pop at count=1: buffer empty next cycle, pc_next=branch_target that cycle, state IDLE.
- pc_cur=0xFFFFFFFF with PC_STEP=1 and an ack: pc_next=0x00000000.
